// File: rtl/gpout_pkg.sv
// Shared register map and control-field positions for the general-purpose output block.
package gpout_pkg;

  localparam logic [2:0] GP_DATA  = 3'd0;
  localparam logic [2:0] GP_SET   = 3'd1;
  localparam logic [2:0] GP_CLR   = 3'd2;
  localparam logic [2:0] GP_TGL   = 3'd3;
  localparam logic [2:0] GP_PULSE = 3'd4;
  localparam logic [2:0] GP_CTRL  = 3'd5;
  localparam logic [2:0] GP_PLEN  = 3'd6;

  localparam int CTRL_SYNC_BIT = 0;

endpackage

// File: rtl/gpout_reg_pulse_timer.sv
// Shared one-shot pulse timer: holds a mask of pulsed bits high for max(len,1) cycles.
module gpout_reg_pulse_timer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [31:0]      mask,
  input  logic [CNT_W-1:0] len,
  output logic [31:0]      pmask,
  output logic [31:0]      pmask_nxt,
  output logic             busy
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      pmask_q, pmask_d;
  logic             busy_q, busy_d;

  always_comb begin
    cnt_d   = cnt_q;
    pmask_d = pmask_q;
    busy_d  = busy_q;
    if (start) begin
      // A retrigger ORs in the new bits and reloads, extending every active pulse.
      pmask_d = pmask_q | mask;
      cnt_d   = (len == '0) ? '0 : len - CNT_W'(1);
      busy_d  = 1'b1;
    end else if (busy_q) begin
      if (cnt_q != '0) begin
        cnt_d = cnt_q - CNT_W'(1);
      end else begin
        pmask_d = '0;
        busy_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      pmask_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      pmask_q <= pmask_d;
      busy_q  <= busy_d;
    end
  end

  assign pmask     = pmask_q;
  assign pmask_nxt = pmask_d;
  assign busy      = busy_q;

endmodule

// File: rtl/gpout_reg.sv
// General-purpose output register block: shadow ALU, immediate or commit-synchronised
// output register, pulse overlay and read mux.
module gpout_reg
  import gpout_pkg::*;
#(
  parameter int          CNT_W     = 16,
  parameter int          PULSE_DEF = 100,
  parameter logic [31:0] RST_VAL   = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic [2:0]  wr_addr,
  input  logic [31:0] wr_data,
  input  logic [2:0]  rd_addr,
  output logic [31:0] rd_data,
  input  logic        commit,
  output logic [31:0] gpout,
  output logic        pulse_busy
);

  logic [31:0]      shadow_q, shadow_d;
  logic [31:0]      out_q, out_d;
  logic [31:0]      gpout_q, gpout_d;
  logic             ctrl_q, ctrl_d;
  logic [CNT_W-1:0] plen_q, plen_d;
  logic             pulse_start;
  logic [31:0]      pmask, pmask_nxt;

  always_comb begin
    shadow_d = shadow_q;
    ctrl_d   = ctrl_q;
    plen_d   = plen_q;
    if (wr_en) begin
      case (wr_addr)
        GP_DATA: shadow_d = wr_data;
        GP_SET:  shadow_d = shadow_q | wr_data;
        GP_CLR:  shadow_d = shadow_q & ~wr_data;
        GP_TGL:  shadow_d = shadow_q ^ wr_data;
        GP_CTRL: ctrl_d   = wr_data[CTRL_SYNC_BIT];
        GP_PLEN: plen_d   = wr_data[CNT_W-1:0];
        default: ;
      endcase
    end
  end

  assign pulse_start = wr_en && (wr_addr == GP_PULSE) && (wr_data != '0);

  // Commit samples the pre-write shadow, so a colliding write waits for the next tick.
  always_comb begin
    out_d = out_q;
    if (!ctrl_q || commit) out_d = shadow_q;
  end

  // Registered from next-state values so pulses appear the cycle after the PULSE write.
  assign gpout_d = out_d | pmask_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_q <= RST_VAL;
      out_q    <= RST_VAL;
      gpout_q  <= RST_VAL;
      ctrl_q   <= 1'b0;
      plen_q   <= CNT_W'(PULSE_DEF);
    end else begin
      shadow_q <= shadow_d;
      out_q    <= out_d;
      gpout_q  <= gpout_d;
      ctrl_q   <= ctrl_d;
      plen_q   <= plen_d;
    end
  end

  gpout_reg_pulse_timer #(.CNT_W(CNT_W)) u_pulse (
    .clk       (clk),
    .rst       (rst),
    .start     (pulse_start),
    .mask      (wr_data),
    .len       (plen_q),
    .pmask     (pmask),
    .pmask_nxt (pmask_nxt),
    .busy      (pulse_busy)
  );

  always_comb begin
    rd_data = '0;
    case (rd_addr)
      GP_DATA:  rd_data = shadow_q;
      GP_SET:   rd_data = gpout_q;
      GP_CLR:   rd_data[0] = ctrl_q;
      GP_TGL:   rd_data[CNT_W-1:0] = plen_q;
      GP_PULSE: rd_data = pmask;
      default:  rd_data = '0;
    endcase
  end

  assign gpout = gpout_q;

endmodule

// File: tb/tb_gpout_reg.sv
// Directed bench for gpout_reg: register map, output timing, commit sync and pulse timer.
module tb_gpout_reg;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [31:0] wr_data;
  logic [2:0]  rd_addr;
  logic [31:0] rd_data;
  logic        commit;
  logic [31:0] gpout;
  logic        pulse_busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  gpout_reg dut (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .commit     (commit),
    .gpout      (gpout),
    .pulse_busy (pulse_busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Drives one write cycle; returns at the negedge right after the capturing posedge.
  task automatic do_wr(input logic [2:0] a, input logic [31:0] d, input logic cm = 1'b0);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = a; wr_data = d; commit = cm;
    @(negedge clk);
    wr_en = 1'b0; commit = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [2:0] a, input logic [31:0] exp);
    rd_addr = a;
    #1;
    chk(tag, rd_data, exp);
  endtask

  // Write in sync_mode=0: gpout still old one cycle after the write, new two cycles after.
  task automatic wr_chk(input string tag, input logic [2:0] a, input logic [31:0] d,
                        input logic [31:0] old_v, input logic [31:0] new_v);
    do_wr(a, d);
    chk({tag, "_old"}, gpout, old_v);
    @(negedge clk);
    chk({tag, "_new"}, gpout, new_v);
  endtask

  initial begin
    int hi0, hi1, hib, chg;
    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; rd_addr = '0; commit = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // 1. reset state
    rd("rst_shadow", 3'd0, 32'h0);
    rd("rst_gpout",  3'd1, 32'h0);
    rd("rst_ctrl",   3'd2, 32'h0);
    rd("rst_plen",   3'd3, 32'd100);
    rd("rst_pmask",  3'd4, 32'h0);
    rd("rst_rd7",    3'd7, 32'h0);
    chk("rst_gp",   gpout, 32'h0);
    chk("rst_busy", {31'b0, pulse_busy}, 32'h0);

    // 2. immediate mode shadow ALU
    wr_chk("data", 3'd0, 32'h0000_00F0, 32'h0,          32'h0000_00F0);
    wr_chk("set",  3'd1, 32'h0000_0001, 32'h0000_00F0, 32'h0000_00F1);
    wr_chk("clr",  3'd2, 32'h0000_0010, 32'h0000_00F1, 32'h0000_00E1);
    wr_chk("tgl",  3'd3, 32'h8000_0000, 32'h0000_00E1, 32'h8000_00E1);
    rd("rd_shadow", 3'd0, 32'h8000_00E1);
    rd("rd_gpout",  3'd1, 32'h8000_00E1);

    // 3. commit-synchronised mode
    do_wr(3'd5, 32'h1);
    rd("rd_ctrl", 3'd2, 32'h1);
    do_wr(3'd0, 32'h0000_00A5);
    chg = 0;
    repeat (10) begin
      @(negedge clk);
      if (gpout !== 32'h8000_00E1) chg++;
    end
    chk("sync_hold", chg, 0);
    do_wr(3'd0, 32'h0000_00A5, 1'b1);
    chk("commit1", gpout, 32'h0000_00A5);
    do_wr(3'd0, 32'h0000_005A, 1'b1);
    chk("collide", gpout, 32'h0000_00A5);
    repeat (3) @(negedge clk);
    chk("collide_hold", gpout, 32'h0000_00A5);
    rd("collide_shadow", 3'd0, 32'h0000_005A);
    @(negedge clk); commit = 1'b1;
    @(negedge clk); commit = 1'b0;
    chk("commit2", gpout, 32'h0000_005A);
    do_wr(3'd5, 32'h0);
    do_wr(3'd0, 32'h0);
    @(negedge clk);
    chk("back_immediate", gpout, 32'h0);

    // 4. single pulse, plen=3 then plen=0
    do_wr(3'd6, 32'd3);
    rd("rd_plen3", 3'd3, 32'd3);
    do_wr(3'd4, 32'h4);
    rd("rd_pmask", 3'd4, 32'h4);
    hi0 = 0; hib = 0;
    for (int i = 0; i < 8; i++) begin
      if (gpout[2]) hi0++;
      if (pulse_busy) hib++;
      @(negedge clk);
    end
    chk("p3_len",  hi0, 3);
    chk("p3_busy", hib, 3);
    do_wr(3'd6, 32'd0);
    do_wr(3'd4, 32'h4);
    hi0 = 0;
    for (int i = 0; i < 6; i++) begin
      if (gpout[2]) hi0++;
      @(negedge clk);
    end
    chk("p0_len", hi0, 1);
    do_wr(3'd4, 32'h0);
    chk("pzero_busy", {31'b0, pulse_busy}, 32'h0);

    // 5. retrigger extends both bits to 5 cycles after the second write
    do_wr(3'd6, 32'd5);
    do_wr(3'd4, 32'h1);
    do_wr(3'd4, 32'h2);
    hi0 = 0; hi1 = 0;
    for (int i = 0; i < 10; i++) begin
      if (gpout[0]) hi0++;
      if (gpout[1]) hi1++;
      @(negedge clk);
    end
    chk("retrig_b0", hi0, 5);
    chk("retrig_b1", hi1, 5);

    // 6. reset aborts a running pulse
    do_wr(3'd6, 32'd50);
    do_wr(3'd4, 32'hFF);
    chk("long_on", gpout, 32'h0000_00FF);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_gp",   gpout, 32'h0);
    chk("abort_busy", {31'b0, pulse_busy}, 32'h0);
    rst = 1'b0;
    rd("abort_plen", 3'd3, 32'd100);
    chg = 0;
    repeat (60) begin
      @(negedge clk);
      if (gpout !== 32'h0 || pulse_busy) chg++;
    end
    chk("no_residual", chg, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
